// File: rtl/j1_pkg.sv
// j1_pkg: shared definitions for the J1 fetch stage.
//   - Opcode-class constants decoded from instruction bits [15:13]
//   - Fetch FSM state encoding
package j1_pkg;

    // Opcode classes for non-literal instructions (bit 15 = 0)
    localparam logic [2:0] OP_JMP  = 3'b000;
    localparam logic [2:0] OP_CJMP = 3'b001;
    localparam logic [2:0] OP_CALL = 3'b010;
    localparam logic [2:0] OP_ALU  = 3'b011;

    // Fetch FSM states
    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/j1_predecode.sv
// j1_predecode: combinational instruction classifier for early branch resolution.
// Ports:
//   i_inst    in   DATA_WIDTH  raw instruction word
//   o_is_lit  out  1           literal (bit 15 set)
//   o_is_jmp  out  1           unconditional jump
//   o_is_cjmp out  1           conditional jump
//   o_is_call out  1           call
//   o_is_alu  out  1           ALU instruction
//   o_target  out  ADDR_WIDTH  inst[12:0] zero-extended/truncated to ADDR_WIDTH
module j1_predecode
    import j1_pkg::*;
#(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 16
) (
    input  logic [DATA_WIDTH-1:0] i_inst,
    output logic                  o_is_lit,
    output logic                  o_is_jmp,
    output logic                  o_is_cjmp,
    output logic                  o_is_call,
    output logic                  o_is_alu,
    output logic [ADDR_WIDTH-1:0] o_target
);

    logic [2:0] w_op;

    assign w_op      = i_inst[15:13];
    // A literal has bit 15 set, so it can never alias the 0xx opcode classes.
    assign o_is_lit  = i_inst[15];
    assign o_is_jmp  = (w_op == OP_JMP);
    assign o_is_cjmp = (w_op == OP_CJMP);
    assign o_is_call = (w_op == OP_CALL);
    assign o_is_alu  = (w_op == OP_ALU);
    assign o_target  = ADDR_WIDTH'(i_inst[12:0]);

endmodule

// File: rtl/j1_fetch_stage.sv
// j1_fetch_stage: J1 instruction-fetch stage.
// Owns the PC, presents it to the memory instruction port, captures the
// combinationally returned word into the IF/ID register, resolves jump/call
// early, and honours execute redirects, stall, halt and resume.
// Ports:
//   clk          in   1           clock, all state on rising edge
//   rst          in   1           synchronous active-high reset
//   pc_o         out  ADDR_WIDTH  fetch address (PC register)
//   inst_i       in   DATA_WIDTH  instruction at pc_o, same cycle
//   stall_i      in   1           hold PC and IF/ID
//   redir_i      in   1           execute redirect (flushes IF/ID)
//   redir_pc_i   in   ADDR_WIDTH  redirect target
//   halt_i       in   1           enter HALT
//   resume_i     in   1           leave HALT
//   if_valid_o   out  1           IF/ID holds a live instruction
//   if_inst_o    out  DATA_WIDTH  IF/ID instruction
//   if_pc_o      out  ADDR_WIDTH  IF/ID instruction address
//   if_pc1_o     out  ADDR_WIDTH  IF/ID address + 1 (call return address)
//   fetch_cnt_o  out  32          instructions delivered into IF/ID
module j1_fetch_stage
    import j1_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 13,
    parameter int                    DATA_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [ADDR_WIDTH-1:0] pc_o,
    input  logic [DATA_WIDTH-1:0] inst_i,
    input  logic                  stall_i,
    input  logic                  redir_i,
    input  logic [ADDR_WIDTH-1:0] redir_pc_i,
    input  logic                  halt_i,
    input  logic                  resume_i,
    output logic                  if_valid_o,
    output logic [DATA_WIDTH-1:0] if_inst_o,
    output logic [ADDR_WIDTH-1:0] if_pc_o,
    output logic [ADDR_WIDTH-1:0] if_pc1_o,
    output logic [31:0]           fetch_cnt_o
);

    fetch_state_t          r_state;
    fetch_state_t          w_state_next;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] w_pc_next;
    logic [ADDR_WIDTH-1:0] w_pc_plus1;
    logic                  w_accept;
    logic                  w_redir;
    logic                  r_if_valid;
    logic [DATA_WIDTH-1:0] r_if_inst;
    logic [ADDR_WIDTH-1:0] r_if_pc;
    logic [ADDR_WIDTH-1:0] r_if_pc1;
    logic [31:0]           r_fetch_cnt;

    logic                  w_is_lit;
    logic                  w_is_jmp;
    logic                  w_is_cjmp;
    logic                  w_is_call;
    logic                  w_is_alu;
    logic [ADDR_WIDTH-1:0] w_target;
    logic                  w_unused_pdec;

    j1_predecode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_predecode (
        .i_inst    (inst_i),
        .o_is_lit  (w_is_lit),
        .o_is_jmp  (w_is_jmp),
        .o_is_cjmp (w_is_cjmp),
        .o_is_call (w_is_call),
        .o_is_alu  (w_is_alu),
        .o_target  (w_target)
    );

    // Only jump/call are resolved here; the rest are decode's business.
    assign w_unused_pdec = w_is_lit ^ w_is_cjmp ^ w_is_alu;

    assign w_pc_plus1 = r_pc + ADDR_WIDTH'(1);

    // FSM next state, accept/redirect qualification and next-PC mux
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_redir      = 1'b0;
        w_pc_next    = r_pc;

        case (r_state)
            ST_BOOT: w_state_next = ST_RUN;
            ST_RUN:  if (halt_i) w_state_next = ST_HALT;
            ST_HALT: if (!halt_i && resume_i) w_state_next = ST_RUN;
            default: w_state_next = ST_BOOT;
        endcase

        // Redirect is a flush: it overrides stall, but BOOT ignores it.
        w_redir  = redir_i && (r_state != ST_BOOT);
        w_accept = (r_state == ST_RUN) && !stall_i && !redir_i;

        if (w_redir) begin
            w_pc_next = redir_pc_i;
        end else if (w_accept && (w_is_jmp || w_is_call)) begin
            w_pc_next = w_target;
        end else if (w_accept) begin
            w_pc_next = w_pc_plus1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_BOOT;
            r_pc        <= RESET_PC;
            r_if_valid  <= 1'b0;
            r_if_inst   <= '0;
            r_if_pc     <= '0;
            r_if_pc1    <= '0;
            r_fetch_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            if (w_accept) begin
                r_if_valid  <= 1'b1;
                r_if_inst   <= inst_i;
                r_if_pc     <= r_pc;
                r_if_pc1    <= w_pc_plus1;
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end else if (w_redir || (r_state == ST_HALT)) begin
                // Squash only the valid bit; payload fields keep their last value.
                r_if_valid <= 1'b0;
            end
        end
    end

    assign pc_o        = r_pc;
    assign if_valid_o  = r_if_valid;
    assign if_inst_o   = r_if_inst;
    assign if_pc_o     = r_if_pc;
    assign if_pc1_o    = r_if_pc1;
    assign fetch_cnt_o = r_fetch_cnt;

endmodule

// File: tb/tb_j1_fetch_stage.sv
module tb_j1_fetch_stage;

    localparam int AW = 13;
    localparam int DW = 16;

    logic          clk;
    logic          rst;
    logic [AW-1:0] pc_o;
    logic [DW-1:0] inst_i;
    logic          stall_i;
    logic          redir_i;
    logic [AW-1:0] redir_pc_i;
    logic          halt_i;
    logic          resume_i;
    logic          if_valid_o;
    logic [DW-1:0] if_inst_o;
    logic [AW-1:0] if_pc_o;
    logic [AW-1:0] if_pc1_o;
    logic [31:0]   fetch_cnt_o;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    int tests_run;
    int tests_failed;

    // Reference model: mode 0 = booting, 1 = running, 2 = halted
    int            m_mode;
    logic [AW-1:0] m_pc;
    logic          m_valid;
    logic [DW-1:0] m_inst;
    logic [AW-1:0] m_ipc;
    logic [AW-1:0] m_ipc1;
    logic [31:0]   m_cnt;

    j1_fetch_stage #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .RESET_PC   (13'h0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_o        (pc_o),
        .inst_i      (inst_i),
        .stall_i     (stall_i),
        .redir_i     (redir_i),
        .redir_pc_i  (redir_pc_i),
        .halt_i      (halt_i),
        .resume_i    (resume_i),
        .if_valid_o  (if_valid_o),
        .if_inst_o   (if_inst_o),
        .if_pc_o     (if_pc_o),
        .if_pc1_o    (if_pc1_o),
        .fetch_cnt_o (fetch_cnt_o)
    );

    assign inst_i = mem[pc_o];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance the reference model by one clock using the current inputs,
    // then let the DUT take the same edge and settle.
    task automatic tick();
        logic [DW-1:0] w;
        logic          taken;
        logic          accept;
        logic          flush;
        logic [AW-1:0] npc;
        int            nmode;
        w = mem[m_pc];
        if (rst) begin
            m_mode = 0; m_pc = '0; m_valid = 0; m_inst = '0;
            m_ipc = '0; m_ipc1 = '0; m_cnt = '0;
        end else begin
            taken  = (w[15:13] == 3'b000) || (w[15:13] == 3'b010);
            accept = (m_mode == 1) && !stall_i && !redir_i;
            flush  = redir_i && (m_mode != 0);
            npc    = m_pc;
            if (flush)       npc = redir_pc_i;
            else if (accept) npc = taken ? w[AW-1:0] : AW'((int'(m_pc) + 1) % (1 << AW));
            if (accept) begin
                m_valid = 1'b1;
                m_inst  = w;
                m_ipc   = m_pc;
                m_ipc1  = AW'((int'(m_pc) + 1) % (1 << AW));
                m_cnt   = m_cnt + 1;
            end else if (flush || m_mode == 2) begin
                m_valid = 1'b0;
            end
            nmode = m_mode;
            if (m_mode == 0)                           nmode = 1;
            else if (m_mode == 1 && halt_i)            nmode = 2;
            else if (m_mode == 2 && !halt_i && resume_i) nmode = 1;
            m_mode = nmode;
            m_pc   = npc;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [AW-1:0] exp_pc [0:4];
        logic          exp_v  [0:4];
        logic [AW-1:0] exp_ip [0:4];
        exp_pc = '{13'd0, 13'd0, 13'd1, 13'd2, 13'd3};
        exp_v  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        exp_ip = '{13'd0, 13'd0, 13'd0, 13'd1, 13'd2};
        rst = 1'b1;
        tick();
        tick();
        tests_run++;
        if ({pc_o, if_valid_o, if_inst_o, if_pc_o, if_pc1_o, fetch_cnt_o} !== '0) begin
            tests_failed++;
            $display("FAIL reset_state: pc=%h v=%b inst=%h ipc=%h ipc1=%h cnt=%0d expected all zero",
                     pc_o, if_valid_o, if_inst_o, if_pc_o, if_pc1_o, fetch_cnt_o);
        end
        mem[0] = 16'h6000; mem[1] = 16'h6001; mem[2] = 16'h6002; mem[3] = 16'h6003;
        rst = 1'b0;
        for (int s = 0; s < 5; s++) begin
            tests_run++;
            if (pc_o !== exp_pc[s] || if_valid_o !== exp_v[s] || (exp_v[s] && if_pc_o !== exp_ip[s])) begin
                tests_failed++;
                $display("FAIL boot_seq[%0d]: pc=%h v=%b ipc=%h expected pc=%h v=%b ipc=%h",
                         s, pc_o, if_valid_o, if_pc_o, exp_pc[s], exp_v[s], exp_ip[s]);
            end
            if (s < 4) tick();
        end
    endtask

    task automatic test_early_jump();
        mem[4] = 16'h0010;
        tick();
        tick();
        tests_run++;
        if (if_valid_o !== 1'b1 || if_inst_o !== 16'h0010 || pc_o !== 13'h010) begin
            tests_failed++;
            $display("FAIL jump: v=%b inst=%h pc=%h expected v=1 inst=0010 pc=010",
                     if_valid_o, if_inst_o, pc_o);
        end
        tick();
        tests_run++;
        if (if_valid_o !== 1'b1 || if_pc_o !== 13'h010) begin
            tests_failed++;
            $display("FAIL jump_no_bubble: v=%b ipc=%h expected v=1 ipc=010", if_valid_o, if_pc_o);
        end
        mem[5] = 16'h4020;
        redir_i = 1'b1; redir_pc_i = 13'h005;
        tick();
        redir_i = 1'b0;
        tick();
        tests_run++;
        if (if_valid_o !== 1'b1 || if_inst_o !== 16'h4020 || if_pc_o !== 13'h005 ||
            if_pc1_o !== 13'h006 || pc_o !== 13'h020) begin
            tests_failed++;
            $display("FAIL call: v=%b inst=%h ipc=%h ipc1=%h pc=%h expected 1 4020 005 006 020",
                     if_valid_o, if_inst_o, if_pc_o, if_pc1_o, pc_o);
        end
    endtask

    task automatic test_redirect_under_stall();
        mem[13'h100] = 16'h6123;
        stall_i = 1'b1; redir_i = 1'b1; redir_pc_i = 13'h100;
        tick();
        stall_i = 1'b0; redir_i = 1'b0;
        tests_run++;
        if (if_valid_o !== 1'b0 || pc_o !== 13'h100) begin
            tests_failed++;
            $display("FAIL redir_stall_flush: v=%b pc=%h expected v=0 pc=100", if_valid_o, pc_o);
        end
        tick();
        tests_run++;
        if (if_valid_o !== 1'b1 || if_inst_o !== 16'h6123 || if_pc_o !== 13'h100) begin
            tests_failed++;
            $display("FAIL redir_target: v=%b inst=%h ipc=%h expected 1 6123 100",
                     if_valid_o, if_inst_o, if_pc_o);
        end
    endtask

    task automatic test_stall();
        logic [31:0] cnt0;
        mem[7] = 16'h6077; mem[8] = 16'h6088;
        redir_i = 1'b1; redir_pc_i = 13'h007;
        tick();
        redir_i = 1'b0;
        tick();
        cnt0 = m_cnt;
        stall_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            tests_run++;
            if (pc_o !== 13'h008 || if_inst_o !== 16'h6077 || if_pc_o !== 13'h007 ||
                fetch_cnt_o !== cnt0 || if_valid_o !== 1'b1) begin
                tests_failed++;
                $display("FAIL stall_hold[%0d]: pc=%h inst=%h ipc=%h cnt=%0d v=%b expected 008 6077 007 %0d 1",
                         c, pc_o, if_inst_o, if_pc_o, fetch_cnt_o, if_valid_o, cnt0);
            end
        end
        stall_i = 1'b0;
        tick();
        tests_run++;
        if (if_pc_o !== 13'h008 || pc_o !== 13'h009 || fetch_cnt_o !== cnt0 + 32'd1) begin
            tests_failed++;
            $display("FAIL stall_release: ipc=%h pc=%h cnt=%0d expected 008 009 %0d",
                     if_pc_o, pc_o, fetch_cnt_o, cnt0 + 32'd1);
        end
    endtask

    task automatic test_wrap();
        mem[13'h1FFF] = 16'h6FFF; mem[0] = 16'h6000;
        redir_i = 1'b1; redir_pc_i = 13'h1FFF;
        tick();
        redir_i = 1'b0;
        tick();
        tests_run++;
        if (if_pc_o !== 13'h1FFF || if_pc1_o !== 13'h0000 || pc_o !== 13'h0000) begin
            tests_failed++;
            $display("FAIL wrap: ipc=%h ipc1=%h pc=%h expected 1fff 0000 0000", if_pc_o, if_pc1_o, pc_o);
        end
        tick();
        tests_run++;
        if (if_pc_o !== 13'h0000 || if_pc1_o !== 13'h0001) begin
            tests_failed++;
            $display("FAIL wrap_next: ipc=%h ipc1=%h expected 0000 0001", if_pc_o, if_pc1_o);
        end
    endtask

    task automatic test_halt();
        mem[13'h20] = 16'h6020; mem[13'h21] = 16'h6021;
        redir_i = 1'b1; redir_pc_i = 13'h020; halt_i = 1'b1;
        tick();
        redir_i = 1'b0; halt_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tests_run++;
            if (if_valid_o !== 1'b0 || pc_o !== 13'h020) begin
                tests_failed++;
                $display("FAIL halt_hold[%0d]: v=%b pc=%h expected v=0 pc=020", c, if_valid_o, pc_o);
            end
            if (c < 3) tick();
        end
        resume_i = 1'b1;
        tick();
        resume_i = 1'b0;
        tick();
        tests_run++;
        if (if_valid_o !== 1'b1 || if_pc_o !== 13'h020 || if_inst_o !== 16'h6020) begin
            tests_failed++;
            $display("FAIL halt_resume: v=%b ipc=%h inst=%h expected 1 020 6020",
                     if_valid_o, if_pc_o, if_inst_o);
        end
        // Re-enter HALT, then reset while halted
        halt_i = 1'b1;
        tick();
        halt_i = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests_run++;
        if (pc_o !== 13'h0000 || if_valid_o !== 1'b0 || fetch_cnt_o !== 32'd0) begin
            tests_failed++;
            $display("FAIL halt_reset: pc=%h v=%b cnt=%0d expected 0000 0 0", pc_o, if_valid_o, fetch_cnt_o);
        end
        tick();
        tests_run++;
        if (pc_o !== 13'h0000 || if_valid_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL halt_reset_boot: pc=%h v=%b expected 0000 0", pc_o, if_valid_o);
        end
        tick();
        tests_run++;
        if (if_valid_o !== 1'b1 || if_pc_o !== 13'h0000 || pc_o !== 13'h0001) begin
            tests_failed++;
            $display("FAIL halt_reset_run: v=%b ipc=%h pc=%h expected 1 0000 0001", if_valid_o, if_pc_o, pc_o);
        end
    endtask

    task automatic test_random();
        int r;
        for (int i = 0; i < (1 << AW); i++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      mem[i] = {3'b000, 13'($urandom)};
            else if (r == 1) mem[i] = {3'b001, 13'($urandom)};
            else if (r == 2) mem[i] = {3'b010, 13'($urandom)};
            else if (r < 6)  mem[i] = {3'b011, 13'($urandom)};
            else             mem[i] = {1'b1, 15'($urandom)};
        end
        for (int c = 0; c < 600; c++) begin
            rst        = ($urandom_range(0, 99) == 0);
            stall_i    = ($urandom_range(0, 3) == 0);
            redir_i    = ($urandom_range(0, 9) == 0);
            redir_pc_i = 13'($urandom);
            halt_i     = ($urandom_range(0, 19) == 0);
            resume_i   = ($urandom_range(0, 2) == 0);
            tick();
            tests_run++;
            if (pc_o !== m_pc || if_valid_o !== m_valid || if_inst_o !== m_inst ||
                if_pc_o !== m_ipc || if_pc1_o !== m_ipc1 || fetch_cnt_o !== m_cnt) begin
                tests_failed++;
                $display("FAIL random[%0d]: pc=%h v=%b inst=%h ipc=%h ipc1=%h cnt=%0d expected %h %b %h %h %h %0d",
                         c, pc_o, if_valid_o, if_inst_o, if_pc_o, if_pc1_o, fetch_cnt_o,
                         m_pc, m_valid, m_inst, m_ipc, m_ipc1, m_cnt);
            end
        end
        rst = 1'b0; stall_i = 1'b0; redir_i = 1'b0; halt_i = 1'b0; resume_i = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst = 1'b1; stall_i = 1'b0; redir_i = 1'b0; redir_pc_i = '0;
        halt_i = 1'b0; resume_i = 1'b0;
        m_mode = 0; m_pc = '0; m_valid = 1'b0; m_inst = '0;
        m_ipc = '0; m_ipc1 = '0; m_cnt = '0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = 16'h6000;
        #2;
        test_reset();
        test_early_jump();
        test_redirect_under_stall();
        test_stall();
        test_wrap();
        test_halt();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
